top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 101 ++++++++++
 tb/tb_top.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// AND gate with a registered copy, edge pulses and optional statistics.
// Define TOP_STATS_EN to build the saturating true-cycle counter and the truth-table coverage bitmap.
module top #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   output logic             c,
   output logic             c_q,
   output logic             c_rise,
   output logic             c_fall,
   output logic [CNT_W-1:0] true_cnt,
   output logic [3:0]       seen,
   output logic             all_seen
);

   assign c = a & b;

   // Reset asserts asynchronously; release is retimed so state first updates on the second edge.
   logic sync1_q;
   logic run_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         sync1_q <= 1'b1;
         run_q   <= sync1_q;
      end
   end

   logic c_d;
   logic rise_d, rise_q;
   logic fall_d, fall_q;

   always_comb begin
      // NOTE: defaults first, so no path leaves a variable unassigned and no latch is inferred.
      c_d    = c_q;
      rise_d = rise_q;
      fall_d = fall_q;
      if (sync1_q) begin
         c_d    = c;
         rise_d = c & ~c_q;
         fall_d = run_q & ~c & c_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q    <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         c_q    <= c_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign c_rise = rise_q;
   assign c_fall = fall_q;

`ifdef TOP_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [3:0]       seen_d, seen_q;

   always_comb begin
      cnt_d  = cnt_q;
      seen_d = seen_q;
      if (sync1_q) begin
         if (c && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
         seen_d[{a, b}] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         seen_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         seen_q <= seen_d;
      end
   end

   assign true_cnt = cnt_q;
   assign seen     = seen_q;
   assign all_seen = &seen_q;
`else
   assign true_cnt = '0;
   assign seen     = '0;
   assign all_seen = 1'b0;
`endif

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: idle-clock vector table, hand-written reset/pulse/saturation
// sequences, and randomized traffic against a sample-history reference model.
module tb_top;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef TOP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk, clk_en, rst_n, a, b;
   logic             c, c_q, c_rise, c_fall, all_seen;
   logic [CNT_W-1:0] true_cnt;
   logic [3:0]       seen;

   int checks;
   int failures;

   top #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b),
      .c(c), .c_q(c_q), .c_rise(c_rise), .c_fall(c_fall),
      .true_cnt(true_cnt), .seen(seen), .all_seen(all_seen)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: every value the design captured since the last reset, oldest first.
   bit       hist[$];
   int       edges_live;
   bit [3:0] m_seen;

   function automatic void model_clear();
      hist.delete();
      edges_live = 0;
      m_seen     = '0;
   endfunction

   function automatic void model_edge(input bit ma, input bit mb);
      if (!rst_n) return;
      edges_live++;
      if (edges_live >= 2) begin
         hist.push_back(ma & mb);
         m_seen[{ma, mb}] = 1'b1;
      end
   endfunction

   function automatic bit exp_cq();
      return (hist.size() == 0) ? 1'b0 : hist[hist.size()-1];
   endfunction

   function automatic bit exp_rise();
      int n = hist.size();
      bit prev;
      if (n == 0) return 1'b0;
      prev = (n >= 2) ? hist[n-2] : 1'b0;
      return hist[n-1] & ~prev;
   endfunction

   function automatic bit exp_fall();
      int n = hist.size();
      if (n < 2) return 1'b0;
      return ~hist[n-1] & hist[n-2];
   endfunction

   function automatic int exp_cnt();
      int ones = 0;
      if (!STATS) return 0;
      foreach (hist[i]) ones += int'(hist[i]);
      return (ones > CNT_MAX) ? CNT_MAX : ones;
   endfunction

   function automatic bit [3:0] exp_seen();
      return STATS ? m_seen : 4'b0000;
   endfunction

   task automatic check_all(input string tag);
      check({tag, " c"},        32'(c),        32'(a & b));
      check({tag, " c_q"},      32'(c_q),      32'(exp_cq()));
      check({tag, " c_rise"},   32'(c_rise),   32'(exp_rise()));
      check({tag, " c_fall"},   32'(c_fall),   32'(exp_fall()));
      check({tag, " excl"},     32'(c_rise & c_fall), 32'(0));
      check({tag, " true_cnt"}, 32'(true_cnt), 32'(exp_cnt()));
      check({tag, " seen"},     32'(seen),     32'(exp_seen()));
      check({tag, " all_seen"}, 32'(all_seen), 32'(exp_seen() == 4'b1111));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge(a, b);
      @(negedge clk);
      check_all(tag);
   endtask

   // Assert reset between edges, check the asynchronous clear, then release before the next edge.
   task automatic mid_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      check({tag, " cleared"}, {20'd0, c_q, c_rise, c_fall, all_seen, seen, true_cnt}, 32'd0);
      check({tag, " c live"}, 32'(c), 32'(a & b));
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic a;
      logic b;
      logic exp_c;
   } vec_t;

   vec_t vecs[8];

   initial begin
      checks   = 0;
      failures = 0;
      clk      = 1'b0;
      clk_en   = 1'b0;
      rst_n    = 1'b0;
      a        = 1'b0;
      b        = 1'b0;
      model_clear();

      vecs[0] = '{1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 1'b0};

      // Clock stopped and reset held: c follows the inputs, everything else stays cleared.
      for (int i = 0; i < 8; i++) begin
         a = vecs[i].a;
         b = vecs[i].b;
         #10;
         check($sformatf("idle vec%0d c", i), 32'(c), 32'(vecs[i].exp_c));
         check($sformatf("idle vec%0d state", i),
               {20'd0, c_q, c_rise, c_fall, all_seen, seen, true_cnt}, 32'd0);
      end

      // Release reset with a=b=1 held: the first edge is swallowed by the synchronizer.
      a = 1'b1;
      b = 1'b1;
      clk_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step("sync e1");
      check("sync e1 hold", 32'(c_q), 32'(0));
      step("and e2");
      check("and e2 rise", {30'd0, c_q, c_rise}, 32'b11);
      check("and e2 cnt", 32'(true_cnt), STATS ? 32'd1 : 32'd0);
      step("and e3");
      check("and e3 rise gone", 32'(c_rise), 32'(0));
      step("and e4");
      b = 1'b0;
      step("drop e5");
      check("drop e5 fall", {30'd0, c_q, c_fall}, 32'b01);
      check("drop e5 cnt", 32'(true_cnt), STATS ? 32'd3 : 32'd0);
      step("drop e6");
      check("drop e6 fall gone", 32'(c_fall), 32'(0));

      // Saturation: twenty more true cycles on a 4-bit counter.
      b = 1'b1;
      for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i));
      check("sat final cnt", 32'(true_cnt), STATS ? 32'(CNT_MAX) : 32'd0);

      // Mid-cycle reset clears a saturated counter; then cover all four input pairs.
      mid_reset("rst1");
      a = 1'b0;
      b = 1'b0;
      step("rst1 sync");
      check("rst1 sync hold", {28'd0, seen}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         a = i[1];
         b = i[0];
         step($sformatf("cover%0d", i));
      end
      check("cover seen", 32'(seen), STATS ? 32'hF : 32'h0);
      check("cover all_seen", 32'(all_seen), 32'(STATS));
      @(negedge clk);
      mid_reset("rst2");

      // Randomized traffic with occasional mid-cycle resets.
      for (int i = 0; i < 400; i++) begin
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) mid_reset($sformatf("rnd rst%0d", i));
         step($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
